// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-requester memory arbiter bus bundle
interface mem_arbiter_if;
    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic [3:0]  m0_wmask_i;
    logic [31:0] m0_wdata_i;
    logic        m0_gnt_o;
    logic [31:0] m0_rdata_o;
    logic        m0_rvalid_o;

    logic        m1_req_i;
    logic [31:0] m1_addr_i;
    logic [3:0]  m1_wmask_i;
    logic [31:0] m1_wdata_i;
    logic        m1_gnt_o;
    logic [31:0] m1_rdata_o;
    logic        m1_rvalid_o;

    logic [31:0] mem_addr_o;
    logic        mem_rstrb_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    // Arbiter side.
    modport slave (
        input  m0_req_i, m0_addr_i, m0_wmask_i, m0_wdata_i,
        output m0_gnt_o, m0_rdata_o, m0_rvalid_o,
        input  m1_req_i, m1_addr_i, m1_wmask_i, m1_wdata_i,
        output m1_gnt_o, m1_rdata_o, m1_rvalid_o,
        output mem_addr_o, mem_rstrb_o, mem_wmask_o, mem_wdata_o,
        input  mem_rdata_i
    );

    // Requesters and memory side.
    modport master (
        output m0_req_i, m0_addr_i, m0_wmask_i, m0_wdata_i,
        input  m0_gnt_o, m0_rdata_o, m0_rvalid_o,
        output m1_req_i, m1_addr_i, m1_wmask_i, m1_wdata_i,
        input  m1_gnt_o, m1_rdata_o, m1_rvalid_o,
        input  mem_addr_o, mem_rstrb_o, mem_wmask_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter onto a single fixed-latency memory
module mem_arbiter #(
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        winner;
    logic        gnt;
    logic        rvalid;
    logic        rstrb;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        winner    = 1'b0;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        rstrb     = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (bus.m0_req_i || bus.m1_req_i) begin
                    // Under contention the side not granted last wins.
                    winner  = (bus.m0_req_i && bus.m1_req_i) ? ~last_q : bus.m1_req_i;
                    owner_d = winner;
                    last_d  = winner;
                    addr_d  = winner ? bus.m1_addr_i  : bus.m0_addr_i;
                    wmask_d = winner ? bus.m1_wmask_i : bus.m0_wmask_i;
                    wdata_d = winner ? bus.m1_wdata_i : bus.m0_wdata_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                gnt       = 1'b1;
                mem_addr  = addr_q;
                mem_wmask = wmask_q;
                mem_wdata = wdata_q;
                if (wmask_q == 4'b0000) begin
                    rstrb   = 1'b1;
                    cnt_d   = 4'(RD_LATENCY);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rvalid  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m0_gnt_o    = gnt & ~owner_q;
    assign bus.m1_gnt_o    = gnt &  owner_q;
    assign bus.m0_rvalid_o = rvalid & ~owner_q;
    assign bus.m1_rvalid_o = rvalid &  owner_q;
    assign bus.m0_rdata_o  = (rvalid && !owner_q) ? bus.mem_rdata_i : 32'h0;
    assign bus.m1_rdata_o  = (rvalid &&  owner_q) ? bus.mem_rdata_i : 32'h0;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_rstrb_o = rstrb;
    assign bus.mem_wmask_o = mem_wmask;
    assign bus.mem_wdata_o = mem_wdata;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LATENCY, default 1, cycles from a memory read strobe to valid mem_rdata_i; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 m0_req_i / m1_req_i  input  1  requester N has a transaction pending.
REQ-005 m0_addr_i / m1_addr_i  input  32  byte address, forwarded unmodified.
REQ-006 m0_wmask_i / m1_wmask_i  input  4  byte write mask; 4'b0000 means read.
REQ-007 m0_wdata_i / m1_wdata_i  input  32  write data.
REQ-008 m0_gnt_o / m1_gnt_o  output  1  one-cycle pulse: request accepted, issued to memory this cycle.
REQ-009 m0_rdata_o / m1_rdata_o  output  32  read data, valid only with the matching rvalid.
REQ-010 m0_rvalid_o / m1_rvalid_o  output  1  one-cycle pulse: read data valid.
REQ-011 mem_addr_o  output  32  memory byte address.
REQ-012 mem_rstrb_o  output  1  memory read strobe.
REQ-013 mem_wmask_o  output  4  memory byte write enables.
REQ-014 mem_wdata_o  output  32  memory write data.
REQ-015 mem_rdata_i  input  32  memory read data, valid RD_LATENCY cycles after the strobe cycle.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT; one transaction in flight at most.
REQ-017 IDLE: if any req_i is high at the clock edge, latch winner id, addr, wmask and wdata, then go to ISSUE; otherwise stay in IDLE.
REQ-018 Arbitration is round-robin; with both requests high, the requester not granted last wins; with one request high, that requester wins.
REQ-019 The last-granted pointer resets to m1, so m0 wins the first contention.
REQ-020 ISSUE lasts exactly one cycle, with these outputs:
- gnt_o of the owner high;
- mem_addr_o, mem_wdata_o and mem_wmask_o from the latched values;
- mem_rstrb_o high only when the latched wmask is 0.
REQ-021 ISSUE exit: a write returns to IDLE; a read goes to WAIT and loads a latency counter with RD_LATENCY.
REQ-022 WAIT: the counter decrements each cycle. In the final WAIT cycle (counter==1), assert the owner's rvalid_o, with rdata_o driven combinationally from mem_rdata_i, then return to IDLE.
REQ-023 Read timing, requests first sampled at edge T:
- ISSUE in cycle T+1;
- rvalid in cycle T+1+RD_LATENCY;
- IDLE in the following cycle.
REQ-024 Write timing: ISSUE in cycle T+1, IDLE in T+2; no write completion pulse beyond gnt.
REQ-025 Outside ISSUE, mem outputs are driven as follows:
- mem_rstrb_o = 0 and mem_wmask_o = 0;
- mem_addr_o and mem_wdata_o = 0.
REQ-026 Each non-owner gnt_o and rvalid_o is 0 at all times; rdata_o of the non-owner is 0.
REQ-027 Requests are sampled only in IDLE. Requesters hold req, addr, wmask and wdata stable until gnt; req may be dropped in the gnt cycle.
REQ-028 A req deasserted before the IDLE sample edge is never granted; no request is queued.
REQ-029 Minimum spacing between grants is 2 cycles for writes and 2+RD_LATENCY cycles for reads.

Reset
REQ-030 rst_n low immediately (asynchronously) forces:
- state IDLE, counter 0, pointer m1;
- all gnt_o, rvalid_o, rdata_o and mem_* outputs 0.
REQ-031 A transaction in flight at reset is abandoned: no gnt or rvalid is produced for it after reset release.
REQ-032 The first IDLE sample occurs on the first rising edge with rst_n high.

Verification
REQ-033 RD_LATENCY=1, m0 reads addr 0x100, memory returns 0xDEADBEEF: m0_gnt and mem_rstrb in T+1 with mem_addr 0x100; m0_rvalid in T+2 with m0_rdata 0xDEADBEEF.
REQ-034 Both requesters hold writes (m0 0x10 wmask 4'b1111, m1 0x20 wmask 4'b0011): grants alternate m0, m1, m0, ... every 2 cycles, and mem_wmask matches the owner.
REQ-035 RD_LATENCY=3, m1 reads 0x40: mem_rstrb for 1 cycle; m1_rvalid exactly 3 cycles later; no m0 outputs toggle.
REQ-036 rst_n pulsed low during WAIT of an m0 read: outputs 0 at once; no m0_rvalid after release; next contention grants m0.
REQ-037 Idle bus with a 1-cycle m1 req pulse landing between sample edges of a busy period: no m1 grant, and mem outputs stay 0 in IDLE.
